traffic_light_monitor: RTL and testbench

- Passive observer on the six lamp outputs of the traffic-light state controller (highway H_*, country C_*).
- Decodes the lamp pattern back into the 2-bit phase code.
- Measures how long each phase lasts and checks the phase order against the fixed sequence.
- Flags illegal lamp combinations, out-of-order transitions, wrong phase durations and stalls. Used in simulation benches and as an on-chip safety checker beside the controller.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/traffic_light_monitor_if.sv | 40 ++++
 rtl/lamp_decode.sv | 37 +++
 rtl/traffic_light_monitor.sv | 173 +++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its monitor.
//   phase_e     : 2-bit phase code (which pair of lamps is lit)
//   mon_state_e : monitor FSM state encoding
//   next_phase  : legal successor of a phase, 10 -> 11 -> 00 -> 01 -> 10
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_HRCG = 2'b00,  // highway red,    country green
    PH_HRCY = 2'b01,  // highway red,    country yellow
    PH_HGCR = 2'b10,  // highway green,  country red
    PH_HYCR = 2'b11   // highway yellow, country red
  } phase_e;

  typedef enum logic [1:0] {
    StUnsync = 2'b00,
    StAlign  = 2'b01,
    StLocked = 2'b10
  } mon_state_e;

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    unique case (p)
      PH_HGCR: n = PH_HYCR;
      PH_HYCR: n = PH_HRCG;
      PH_HRCG: n = PH_HRCY;
      PH_HRCY: n = PH_HGCR;
      default: n = PH_HGCR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp and monitor-result bundle for traffic_light_monitor.
//   master : lamp driver side (drives the six lamps, observes results)
//   slave  : monitor side (observes lamps, drives results)
// Signals:
//   H_R/H_Y/H_G, C_R/C_Y/C_G : highway / country lamps
//   phase      : decoded phase of last legal sample
//   locked     : monitor synchronised to phase boundaries
//   dwell      : cycles in current phase, saturating (CW bits)
//   illegal_err, seq_err, time_err, stall_err : one-cycle error pulses
//   err_count  : saturating error total (zero unless MON_ERR_COUNT_EN)
interface traffic_light_monitor_if #(
  parameter int unsigned CW = 8
);

  logic                  H_R;
  logic                  H_Y;
  logic                  H_G;
  logic                  C_R;
  logic                  C_Y;
  logic                  C_G;
  traffic_pkg::phase_e   phase;
  logic                  locked;
  logic [CW-1:0]         dwell;
  logic                  illegal_err;
  logic                  seq_err;
  logic                  time_err;
  logic                  stall_err;
  logic [7:0]            err_count;

  modport master (
    output H_R, H_Y, H_G, C_R, C_Y, C_G,
    input  phase, locked, dwell, illegal_err, seq_err, time_err, stall_err, err_count
  );

  modport slave (
    input  H_R, H_Y, H_G, C_R, C_Y, C_G,
    output phase, locked, dwell, illegal_err, seq_err, time_err, stall_err, err_count
  );

endinterface

// File: rtl/lamp_decode.sv
// Combinational decoder: six lamps -> {legal, phase}. A pattern is legal only
// when exactly one of the four defined lamp pairs is lit; phase_o is 00 when
// the pattern is illegal and must be ignored by the consumer.
// Ports:
//   h_r_i, h_y_i, h_g_i : highway lamps
//   c_r_i, c_y_i, c_g_i : country lamps
//   legal_o             : pattern is one of the four legal phases
//   phase_o             : decoded phase code
module lamp_decode
  import traffic_pkg::*;
(
  input  logic   h_r_i,
  input  logic   h_y_i,
  input  logic   h_g_i,
  input  logic   c_r_i,
  input  logic   c_y_i,
  input  logic   c_g_i,
  output logic   legal_o,
  output phase_e phase_o
);

  logic [5:0] lamps;
  assign lamps = {h_r_i, h_y_i, h_g_i, c_r_i, c_y_i, c_g_i};

  always_comb begin
    legal_o = 1'b1;
    phase_o = PH_HRCG;
    case (lamps)
      6'b100_001: phase_o = PH_HRCG;
      6'b100_010: phase_o = PH_HRCY;
      6'b001_100: phase_o = PH_HGCR;
      6'b010_100: phase_o = PH_HYCR;
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light controller lamps. Decodes the lamp
// pattern into a phase, measures each phase's dwell and checks phase order,
// dwell length, stalls and illegal lamp combinations. All outputs are
// registered and reflect the lamp sample taken on the previous rising edge.
// Optional build macro: MON_ERR_COUNT_EN enables the saturating err_count;
// otherwise err_count is tied to zero.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high reset
//   mon_io : traffic_light_monitor_if.slave (lamps in, results out)
// Parameters: X/Y/Z expected dwells (highway green, country green, yellow),
//   CW dwell counter width (must match the interface), STALL stuck threshold
//   (must exceed max(X,Y,Z) and be below 2^CW).
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned X     = 6,
  parameter int unsigned Y     = 4,
  parameter int unsigned Z     = 3,
  parameter int unsigned CW    = 8,
  parameter int unsigned STALL = 32
) (
  input logic                    clk,
  input logic                    reset,
  traffic_light_monitor_if.slave mon_io
);

  localparam logic [CW-1:0] DwellMax = {CW{1'b1}};
  localparam logic [CW-1:0] StallPre = CW'(STALL - 1);

  logic   dec_legal;
  phase_e dec_phase;

  lamp_decode u_lamp_decode (
    .h_r_i   (mon_io.H_R),
    .h_y_i   (mon_io.H_Y),
    .h_g_i   (mon_io.H_G),
    .c_r_i   (mon_io.C_R),
    .c_y_i   (mon_io.C_Y),
    .c_g_i   (mon_io.C_G),
    .legal_o (dec_legal),
    .phase_o (dec_phase)
  );

  function automatic logic [CW-1:0] expected_dwell(input phase_e p);
    logic [CW-1:0] e;
    unique case (p)
      PH_HGCR: e = CW'(X);
      PH_HRCG: e = CW'(Y);
      default: e = CW'(Z);
    endcase
    return e;
  endfunction

  mon_state_e    state_d, state_q;
  phase_e        phase_d, phase_q;
  logic [CW-1:0] dwell_d, dwell_q;
  logic          illegal_d, illegal_q;
  logic          seq_d, seq_q;
  logic          time_d, time_q;
  logic          stall_d, stall_q;

  logic [CW-1:0] dwell_inc;
  logic          changed;
  logic          in_order;

  assign dwell_inc = (dwell_q == DwellMax) ? dwell_q : dwell_q + 1'b1;
  assign changed   = (dec_phase != phase_q);
  assign in_order  = (dec_phase == next_phase(phase_q));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    illegal_d = 1'b0;
    seq_d     = 1'b0;
    time_d    = 1'b0;
    stall_d   = 1'b0;
    if (!dec_legal) begin
      // Illegal sample wins over everything; phase keeps the last legal value.
      illegal_d = 1'b1;
      dwell_d   = '0;
      state_d   = StUnsync;
    end else begin
      unique case (state_q)
        StUnsync: begin
          phase_d = dec_phase;
          dwell_d = CW'(1);
          state_d = StAlign;
        end
        StAlign: begin
          if (changed) begin
            // First dwell after sync is partial, so no timing check here.
            phase_d = dec_phase;
            dwell_d = CW'(1);
            if (in_order) state_d = StLocked;
            else          seq_d   = 1'b1;
          end else begin
            dwell_d = dwell_inc;
            stall_d = (dwell_q == StallPre);
          end
        end
        StLocked: begin
          if (changed) begin
            time_d  = (dwell_q != expected_dwell(phase_q));
            phase_d = dec_phase;
            dwell_d = CW'(1);
            if (!in_order) begin
              seq_d   = 1'b1;
              state_d = StAlign;
            end
          end else begin
            dwell_d = dwell_inc;
            stall_d = (dwell_q == StallPre);
          end
        end
        default: state_d = StUnsync;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StUnsync;
      phase_q   <= PH_HRCG;
      dwell_q   <= '0;
      illegal_q <= 1'b0;
      seq_q     <= 1'b0;
      time_q    <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      illegal_q <= illegal_d;
      seq_q     <= seq_d;
      time_q    <= time_d;
      stall_q   <= stall_d;
    end
  end

  assign mon_io.phase       = phase_q;
  assign mon_io.locked      = (state_q == StLocked);
  assign mon_io.dwell       = dwell_q;
  assign mon_io.illegal_err = illegal_q;
  assign mon_io.seq_err     = seq_q;
  assign mon_io.time_err    = time_q;
  assign mon_io.stall_err   = stall_q;

`ifdef MON_ERR_COUNT_EN
  // Counts the pulses being registered this edge, so err_count moves together
  // with the pulse outputs.
  logic [7:0] err_count_d, err_count_q;
  logic [2:0] n_err;
  logic [8:0] err_sum;

  always_comb begin
    n_err       = 3'(illegal_d) + 3'(seq_d) + 3'(time_d) + 3'(stall_d);
    err_sum     = 9'(err_count_q) + 9'(n_err);
    err_count_d = err_sum[8] ? 8'hff : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign mon_io.err_count = err_count_q;
`else
  assign mon_io.err_count = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with X=6, Y=4, Z=3, CW=8, STALL=32.
module tb_traffic_light_monitor;

`ifdef MON_ERR_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  // Lamp order {H_R, H_Y, H_G, C_R, C_Y, C_G}
  localparam logic [5:0] L_HGCR = 6'b001_100;
  localparam logic [5:0] L_HYCR = 6'b010_100;
  localparam logic [5:0] L_HRCG = 6'b100_001;
  localparam logic [5:0] L_HRCY = 6'b100_010;
  localparam logic [5:0] L_BAD  = 6'b001_001;  // H_G and C_G together
  localparam logic [5:0] L_OFF  = 6'b000_000;
  localparam logic [5:0] L_ALL  = 6'b111_111;

  // Error bit order {illegal, seq, time, stall}
  localparam logic [3:0] E_NONE = 4'b0000;
  localparam logic [3:0] E_ILL  = 4'b1000;
  localparam logic [3:0] E_SEQ  = 4'b0100;
  localparam logic [3:0] E_TIME = 4'b0010;
  localparam logic [3:0] E_STL  = 4'b0001;

  typedef struct {
    logic [5:0] lamps;
    logic [1:0] ph;
    logic       lk;
    logic [7:0] dw;
    logic [3:0] err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ecnt_exp = 0;
  int   stall_seen = 0;
  vec_t vecs[$];

  traffic_light_monitor_if #(.CW(8)) mon_if ();

  traffic_light_monitor #(
    .X     (6),
    .Y     (4),
    .Z     (3),
    .CW    (8),
    .STALL (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mon_io (mon_if)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [5:0] l, input logic [1:0] ph, input logic lk,
                     input int dw, input logic [3:0] err);
    vec_t v;
    v.lamps = l;
    v.ph    = ph;
    v.lk    = lk;
    v.dw    = 8'(dw);
    v.err   = err;
    vecs.push_back(v);
  endtask

  // n error-free samples of one phase, dwell counting up from first_dw
  task automatic add_run(input logic [5:0] l, input logic [1:0] ph, input logic lk,
                         input int first_dw, input int n);
    for (int i = 0; i < n; i++) add(l, ph, lk, first_dw + i, E_NONE);
  endtask

  task automatic step(input logic [5:0] l);
    {mon_if.H_R, mon_if.H_Y, mon_if.H_G, mon_if.C_R, mon_if.C_Y, mon_if.C_G} = l;
    @(posedge clk);
    #1;
  endtask

  task automatic count_errs(input logic [3:0] err);
    if (CntEn && reset == 1'b0) begin
      ecnt_exp = ecnt_exp + $countones(err);
      if (ecnt_exp > 255) ecnt_exp = 255;
    end
  endtask

  task automatic check(input string name, input logic [1:0] ph, input logic lk,
                       input logic [7:0] dw, input logic [3:0] err);
    logic [22:0] got, exp;
    got = {mon_if.phase, mon_if.locked, mon_if.dwell, mon_if.illegal_err,
           mon_if.seq_err, mon_if.time_err, mon_if.stall_err, mon_if.err_count};
    exp = {ph, lk, dw, err, 8'(ecnt_exp)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ph=%b lk=%b dw=%0d err=%b cnt=%0d, expected ph=%b lk=%b dw=%0d err=%b cnt=%0d",
               name, got[22:21], got[20], got[19:12], got[11:8], got[7:0],
               ph, lk, dw, err, ecnt_exp);
    end
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      step(vecs[i].lamps);
      count_errs(vecs[i].err);
      check($sformatf("%s[%0d]", tag, i), vecs[i].ph, vecs[i].lk, vecs[i].dw, vecs[i].err);
    end
    vecs.delete();
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    ecnt_exp = 0;
    step(L_HRCG);
    check(name, 2'b00, 1'b0, 8'd0, E_NONE);
    step(L_OFF);
    reset = 1'b0;
  endtask

  initial begin
    // Table 1: sync, lock, illegal sample, long green, out-of-order jump.
    add_run(L_HGCR, 2'b10, 1'b0, 1, 4);   // partial first dwell, ALIGN
    add_run(L_HYCR, 2'b11, 1'b1, 1, 3);   // first change locks
    add_run(L_HRCG, 2'b00, 1'b1, 1, 4);
    add_run(L_HRCY, 2'b01, 1'b1, 1, 3);
    add_run(L_HGCR, 2'b10, 1'b1, 1, 6);
    add_run(L_HYCR, 2'b11, 1'b1, 1, 3);
    add_run(L_HRCG, 2'b00, 1'b1, 1, 4);
    add_run(L_HRCY, 2'b01, 1'b1, 1, 3);
    add_run(L_HGCR, 2'b10, 1'b1, 1, 2);
    add(L_BAD, 2'b10, 1'b0, 0, E_ILL);    // phase held, dwell cleared
    add_run(L_HGCR, 2'b10, 1'b0, 1, 2);   // resync into ALIGN
    add_run(L_HYCR, 2'b11, 1'b1, 1, 3);
    add_run(L_HRCG, 2'b00, 1'b1, 1, 4);
    add_run(L_HRCY, 2'b01, 1'b1, 1, 3);
    add_run(L_HGCR, 2'b10, 1'b1, 1, 7);   // one cycle too long
    add(L_HYCR, 2'b11, 1'b1, 1, E_TIME);
    add_run(L_HYCR, 2'b11, 1'b1, 2, 2);
    add_run(L_HRCG, 2'b00, 1'b1, 1, 4);
    add_run(L_HRCY, 2'b01, 1'b1, 1, 3);
    add_run(L_HGCR, 2'b10, 1'b1, 1, 6);
    add(L_HRCG, 2'b00, 1'b0, 1, E_SEQ);   // 10 -> 00 skips 11
    add_run(L_HRCG, 2'b00, 1'b0, 2, 2);

    step(L_OFF);
    step(L_OFF);
    do_reset("reset");
    run_table("t1");

    // Stall: stay in 00 (now at dwell 3, ALIGN) until dwell saturates.
    stall_seen = 0;
    for (int k = 4; k <= 300; k++) begin
      step(L_HRCG);
      stall_seen += int'(mon_if.stall_err);
      count_errs(k == 32 ? E_STL : E_NONE);
      if (k == 31)  check("stall_pre",  2'b00, 1'b0, 8'd31,  E_NONE);
      if (k == 32)  check("stall_hit",  2'b00, 1'b0, 8'd32,  E_STL);
      if (k == 33)  check("stall_post", 2'b00, 1'b0, 8'd33,  E_NONE);
      if (k == 254) check("dwell_254",  2'b00, 1'b0, 8'd254, E_NONE);
      if (k == 255) check("dwell_255",  2'b00, 1'b0, 8'd255, E_NONE);
      if (k == 300) check("dwell_sat",  2'b00, 1'b0, 8'd255, E_NONE);
    end
    checks++;
    if (stall_seen != 1) begin
      errors++;
      $display("FAIL stall_once: got %0d stall pulses, expected 1", stall_seen);
    end

    // Monitor reset mid-phase, then time and seq together on one change.
    do_reset("mid_reset");
    add_run(L_HGCR, 2'b10, 1'b0, 1, 2);
    add_run(L_HYCR, 2'b11, 1'b1, 1, 3);
    add_run(L_HRCG, 2'b00, 1'b1, 1, 2);
    add(L_HGCR, 2'b10, 1'b0, 1, E_SEQ | E_TIME);  // 00 -> 10, short green
    add(L_HGCR, 2'b10, 1'b0, 2, E_NONE);
    add(L_OFF,  2'b10, 1'b0, 0, E_ILL);
    add(L_HYCR, 2'b11, 1'b0, 1, E_NONE);
    run_table("t2");

    // Long burst of illegal samples drives err_count to saturation.
    for (int k = 0; k < 300; k++) begin
      step(L_ALL);
      count_errs(E_ILL);
    end
    check("ill_burst", 2'b11, 1'b0, 8'd0, E_ILL);
    step(L_HGCR);
    check("after_burst", 2'b10, 1'b0, 8'd1, E_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
